// File: rtl/fft_pkg.sv
// Shared constants, FSM encodings and the bin-order helper for the FFT stream adapter.
package fft_pkg;

  localparam int unsigned FFT_N        = 32;
  localparam int unsigned FFT_I        = 19;
  localparam int unsigned FFT_F        = 11;
  localparam int unsigned FFT_CORE_LAT = 5;
  localparam int unsigned FFT_W        = FFT_I + FFT_F;
  localparam int unsigned FFT_IW       = $clog2(FFT_N);

  typedef enum logic {
    InLoad,
    InFull
  } in_state_e;

  typedef enum logic [1:0] {
    OutIdle,
    OutWait,
    OutUnload
  } out_state_e;

  // Reverses the low iw bits of idx; higher bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned iw);
    logic [31:0] r;
    r = '0;
    for (int unsigned b = 0; b < iw; b++) begin
      r[5'(iw - 1 - b)] = idx[5'(b)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_loader.sv
// Input side: collects N serial samples into a frame buffer, flags framing errors
// and holds the frame until the top level launches the core.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int unsigned N = FFT_N,
  parameter int unsigned W = FFT_W,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic           i_valid,
  input  logic [W-1:0]   i_data,
  input  logic           i_last,
  input  logic           i_start,
  output logic           o_ready,
  output logic           o_full,
  output logic [N*W-1:0] o_frame,
  output logic           o_frame_err
);

  in_state_e      r_state, w_state_d;
  logic [IW-1:0]  r_cnt, w_cnt_d;
  logic           r_err, w_err_d;
  logic [N*W-1:0] r_buf;
  logic           w_accept;

  assign o_ready     = i_en & ~i_rst & (r_state == InLoad);
  assign w_accept    = o_ready & i_valid;
  assign o_full      = (r_state == InFull);
  assign o_frame     = r_buf;
  assign o_frame_err = r_err & i_en & ~i_rst;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_err_d   = r_err;
    if (i_en) begin
      w_err_d = 1'b0;
      if (i_start) begin
        w_state_d = InLoad;
      end
      if (w_accept) begin
        if (r_cnt == IW'(N - 1)) begin
          // A full frame is kept even when IN_last was missing.
          w_state_d = InFull;
          w_cnt_d   = '0;
          w_err_d   = ~i_last;
        end else if (i_last) begin
          w_cnt_d = '0;
          w_err_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= InLoad;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_err   <= w_err_d;
    end
  end

  // Frame storage is not reset; only the counters decide what is valid.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_buf[r_cnt*W +: W] <= i_data;
    end
  end

endmodule

// File: rtl/fft_stream_adapter.sv
// Streaming wrapper around the parallel N-point FFT core: serial real samples in,
// one complex bin per beat out, with input and output sides overlapping.
module fft_stream_adapter
  import fft_pkg::*;
#(
  parameter int unsigned N        = FFT_N,
  parameter int unsigned I        = FFT_I,
  parameter int unsigned F        = FFT_F,
  parameter int unsigned CORE_LAT = FFT_CORE_LAT,
  localparam int unsigned W       = I + F,
  localparam int unsigned IW      = $clog2(N),
  localparam int unsigned LW      = $clog2(CORE_LAT + 1)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic           IN_valid,
  input  logic [W-1:0]   IN_data,
  input  logic           IN_last,
  output logic           IN_ready,
  input  logic           BITREV_MODE,
  output logic [N*W-1:0] CORE_in,
  output logic           CORE_start,
  input  logic [N*W-1:0] CORE_res_r,
  input  logic [N*W-1:0] CORE_res_i,
  output logic           OUT_valid,
  input  logic           OUT_ready,
  output logic [W-1:0]   OUT_r,
  output logic [W-1:0]   OUT_i,
  output logic [IW-1:0]  OUT_idx,
  output logic           OUT_last,
  output logic           FRAME_ERR
);

  out_state_e     r_out_state, w_out_state_d;
  logic [IW-1:0]  r_out_cnt, w_out_cnt_d;
  logic [LW-1:0]  r_lat_cnt, w_lat_cnt_d;
  logic           r_mode, w_mode_d;
  logic [N*W-1:0] r_res_r, r_res_i;
  logic           w_full, w_start, w_valid, w_hs, w_capture;
  logic [IW-1:0]  w_idx;

  fft_frame_loader #(
    .N (N),
    .W (W)
  ) u_loader (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_en        (EN),
    .i_valid     (IN_valid),
    .i_data      (IN_data),
    .i_last      (IN_last),
    .i_start     (w_start),
    .o_ready     (IN_ready),
    .o_full      (w_full),
    .o_frame     (CORE_in),
    .o_frame_err (FRAME_ERR)
  );

  assign w_start    = EN & ~RST & w_full & (r_out_state == OutIdle);
  assign w_valid    = EN & ~RST & (r_out_state == OutUnload);
  assign w_hs       = w_valid & OUT_ready;
  assign CORE_start = w_start;

  always_comb begin
    w_out_state_d = r_out_state;
    w_out_cnt_d   = r_out_cnt;
    w_lat_cnt_d   = r_lat_cnt;
    w_mode_d      = r_mode;
    w_capture     = 1'b0;
    if (EN && !RST) begin
      case (r_out_state)
        OutIdle: begin
          if (w_start) begin
            w_out_state_d = OutWait;
            w_lat_cnt_d   = '0;
            w_mode_d      = BITREV_MODE;
          end
        end
        OutWait: begin
          // lat_cnt only advances on EN-high cycles, matching the core pipeline.
          if (r_lat_cnt == LW'(CORE_LAT - 1)) begin
            w_out_state_d = OutUnload;
            w_capture     = 1'b1;
          end else begin
            w_lat_cnt_d = r_lat_cnt + 1'b1;
          end
        end
        OutUnload: begin
          if (w_hs) begin
            if (r_out_cnt == IW'(N - 1)) begin
              w_out_cnt_d   = '0;
              w_out_state_d = OutIdle;
            end else begin
              w_out_cnt_d = r_out_cnt + 1'b1;
            end
          end
        end
        default: w_out_state_d = OutIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_state <= OutIdle;
      r_out_cnt   <= '0;
      r_lat_cnt   <= '0;
      r_mode      <= 1'b0;
    end else begin
      r_out_state <= w_out_state_d;
      r_out_cnt   <= w_out_cnt_d;
      r_lat_cnt   <= w_lat_cnt_d;
      r_mode      <= w_mode_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_capture) begin
      r_res_r <= CORE_res_r;
      r_res_i <= CORE_res_i;
    end
  end

  assign w_idx     = r_mode ? IW'(bitrev(32'(r_out_cnt), IW)) : r_out_cnt;
  assign OUT_idx   = w_idx;
  assign OUT_r     = r_res_r[w_idx*W +: W];
  assign OUT_i     = r_res_i[w_idx*W +: W];
  assign OUT_valid = w_valid;
  assign OUT_last  = ~RST & (r_out_state == OutUnload) & (r_out_cnt == IW'(N - 1));

endmodule

// File: tb/tb_fft_stream_adapter.sv
// Directed bench for fft_stream_adapter with a behavioural DFT core and an output scoreboard.
module tb_fft_stream_adapter;

  localparam int N   = 32;
  localparam int I   = 19;
  localparam int F   = 11;
  localparam int LAT = 5;
  localparam int W   = I + F;
  localparam int IW  = 5;
  localparam real PI = 3.14159265358979323846;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           EN = 1'b1;
  logic           IN_valid = 1'b0;
  logic [W-1:0]   IN_data = '0;
  logic           IN_last = 1'b0;
  logic           IN_ready;
  logic           BITREV_MODE = 1'b0;
  logic [N*W-1:0] CORE_in;
  logic           CORE_start;
  logic [N*W-1:0] CORE_res_r, CORE_res_i;
  logic           OUT_valid;
  logic           OUT_ready = 1'b1;
  logic [W-1:0]   OUT_r, OUT_i;
  logic [IW-1:0]  OUT_idx;
  logic           OUT_last;
  logic           FRAME_ERR;

  fft_stream_adapter #(
    .N        (N),
    .I        (I),
    .F        (F),
    .CORE_LAT (LAT)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .EN          (EN),
    .IN_valid    (IN_valid),
    .IN_data     (IN_data),
    .IN_last     (IN_last),
    .IN_ready    (IN_ready),
    .BITREV_MODE (BITREV_MODE),
    .CORE_in     (CORE_in),
    .CORE_start  (CORE_start),
    .CORE_res_r  (CORE_res_r),
    .CORE_res_i  (CORE_res_i),
    .OUT_valid   (OUT_valid),
    .OUT_ready   (OUT_ready),
    .OUT_r       (OUT_r),
    .OUT_i       (OUT_i),
    .OUT_idx     (OUT_idx),
    .OUT_last    (OUT_last),
    .FRAME_ERR   (FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  r;
    logic [W-1:0]  i;
    logic          last;
  } beat_t;

  beat_t         q[$];
  logic [W-1:0]  hist_r[$];
  logic [IW-1:0] hist_idx[$];
  int            n_tests = 0;
  int            n_fail = 0;

  // Values applied to the DUT inputs just after the next rising edge.
  bit            s_rst = 1'b1, s_en = 1'b1, s_valid = 1'b0, s_last = 1'b0, s_mode = 1'b0;
  bit            stall = 1'b0;
  logic [W-1:0]  s_data = '0;
  bit            pv_stall = 1'b0;
  beat_t         pv;

  function automatic int tb_bitrev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < IW; b++) if (v[b]) r |= (1 << (IW - 1 - b));
    return r;
  endfunction

  function automatic logic [N*W-1:0] dft(input logic [N*W-1:0] x, input bit imag);
    logic [N*W-1:0]      o;
    logic signed [W-1:0] xs;
    longint              v;
    real                 acc, ang;
    o = '0;
    for (int k = 0; k < N; k++) begin
      acc = 0.0;
      for (int n = 0; n < N; n++) begin
        xs  = x[n*W +: W];
        v   = xs;
        ang = 2.0 * PI * real'(k * n) / real'(N);
        acc = acc + (imag ? -real'(v) * $sin(ang) : real'(v) * $cos(ang));
      end
      v = longint'(acc);
      o[k*W +: W] = v[W-1:0];
    end
    return o;
  endfunction

  function automatic logic [W-1:0] gen(input int pat, input int k);
    int t;
    case (pat)
      0:       t = k << 11;
      1:       t = (k * 37 - 500) << 4;
      2:       t = ((k % 5) - 2) * 1000 + k * k;
      default: t = 3000 - (k << 9);
    endcase
    return W'(t);
  endfunction

  // Behavioural core: results are only valid in the single cycle the adapter should capture.
  logic [N*W-1:0] cm_r, cm_i;
  bit             cm_active = 1'b0;
  int             cm_cnt = 0;

  always @(posedge CLK) begin
    if (RST) begin
      cm_active <= 1'b0;
    end else if (EN) begin
      if (CORE_start) begin
        cm_r      <= dft(CORE_in, 1'b0);
        cm_i      <= dft(CORE_in, 1'b1);
        cm_active <= 1'b1;
        cm_cnt    <= 0;
      end else if (cm_active) begin
        if (cm_cnt == LAT - 1) cm_active <= 1'b0;
        else cm_cnt <= cm_cnt + 1;
      end
    end
  end

  assign CORE_res_r = (cm_active && cm_cnt == LAT - 1) ? cm_r : '1;
  assign CORE_res_i = (cm_active && cm_cnt == LAT - 1) ? cm_i : '1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int pat, input bit mode);
    logic [N*W-1:0] x, re, im;
    int             idx;
    for (int k = 0; k < N; k++) x[k*W +: W] = gen(pat, k);
    re = dft(x, 1'b0);
    im = dft(x, 1'b1);
    for (int j = 0; j < N; j++) begin
      idx = mode ? tb_bitrev(j) : j;
      q.push_back('{idx: IW'(idx), r: re[idx*W +: W], i: im[idx*W +: W], last: (j == N - 1)});
    end
  endtask

  task automatic mon();
    beat_t e;
    if (pv_stall && OUT_valid) begin
      chk("hold_idx", OUT_idx, pv.idx);
      chk("hold_r", OUT_r, pv.r);
      chk("hold_i", OUT_i, pv.i);
      chk("hold_last", OUT_last, pv.last);
    end
    if (OUT_valid && OUT_ready) begin
      chk("beat_expected", 64'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("beat_idx", OUT_idx, e.idx);
        chk("beat_r", OUT_r, e.r);
        chk("beat_i", OUT_i, e.i);
        chk("beat_last", OUT_last, e.last);
      end
      hist_idx.push_back(OUT_idx);
      hist_r.push_back(OUT_r);
    end
    pv_stall = OUT_valid && !OUT_ready;
    pv       = '{idx: OUT_idx, r: OUT_r, i: OUT_i, last: OUT_last};
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    RST         = s_rst;
    EN          = s_en;
    IN_valid    = s_valid;
    IN_data     = s_data;
    IN_last     = s_last;
    BITREV_MODE = s_mode;
    OUT_ready   = stall ? ~OUT_ready : 1'b1;
    @(negedge CLK);
    mon();
  endtask

  // Returns at the sample point of the cycle whose edge accepts the final sample.
  task automatic send_frame(input int pat, input bit mode, input int ns, input bit push);
    int to;
    s_mode = mode;
    if (push) push_frame(pat, mode);
    for (int k = 0; k < ns; k++) begin
      s_valid = 1'b1;
      s_data  = gen(pat, k);
      s_last  = (k == ns - 1);
      step();
      to = 0;
      while (!IN_ready && to < 300) begin
        step();
        to++;
      end
      if (to >= 300) chk("in_ready_timeout", IN_ready, 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (q.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  initial begin
    int n, mark;
    bit got, seen;

    // Reset held for three cycles with EN high.
    repeat (3) begin
      step();
      chk("rst_in_ready", IN_ready, 0);
      chk("rst_out_valid", OUT_valid, 0);
      chk("rst_core_start", CORE_start, 0);
      chk("rst_frame_err", FRAME_ERR, 0);
    end
    s_rst = 1'b0;
    step();
    chk("post_rst_in_ready", IN_ready, 1);
    chk("post_rst_idx", OUT_idx, 0);
    chk("post_rst_out_valid", OUT_valid, 0);

    // Ramp frame, natural order: start and first-beat latency, DC bin.
    send_frame(0, 1'b0, N, 1'b1);
    chk("start_early", CORE_start, 0);
    step();
    chk("start_lat", CORE_start, 1);
    n = 0;
    do begin
      step();
      n++;
    end while (!OUT_valid && n < 20);
    chk("first_valid_lat", n, 6);
    chk("dc_idx", OUT_idx, 0);
    chk("dc_r", OUT_r, 1015808);
    chk("dc_i", OUT_i, 0);
    chk("dc_last", OUT_last, 0);
    wait_drain(100);

    // Bit-reversed order.
    mark = hist_idx.size();
    send_frame(1, 1'b1, N, 1'b1);
    wait_drain(200);
    chk("brev_idx1", hist_idx[mark+1], 16);
    chk("brev_idx2", hist_idx[mark+2], 8);
    chk("brev_idx31", hist_idx[mark+31], 31);

    // Back-pressure on the output while the next frame loads.
    stall = 1'b1;
    send_frame(2, 1'b0, N, 1'b1);
    send_frame(3, 1'b0, N, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      step();
      chk("full_blocks_in", IN_ready, 0);
      if (OUT_valid && OUT_ready && OUT_last) got = 1'b1;
    end
    chk("last_beat_seen", got, 1);
    step();
    chk("start_after_last", CORE_start, 1);
    stall = 1'b0;
    wait_drain(300);

    // Early IN_last: discarded partial frame, then a clean frame.
    send_frame(0, 1'b0, 10, 1'b0);
    step();
    chk("frame_err_pulse", FRAME_ERR, 1);
    seen = CORE_start;
    step();
    chk("frame_err_clear", FRAME_ERR, 0);
    seen |= CORE_start;
    repeat (6) begin
      step();
      seen |= CORE_start;
    end
    chk("no_start_on_err", seen, 0);
    chk("err_in_ready", IN_ready, 1);
    mark = hist_r.size();
    send_frame(0, 1'b0, N, 1'b1);
    wait_drain(100);
    chk("err_dc_idx", hist_idx[mark], 0);
    chk("err_dc_r", hist_r[mark], 1015808);

    // EN low for three cycles while waiting on the core.
    send_frame(1, 1'b0, N, 1'b1);
    step();
    chk("en_start", CORE_start, 1);
    step();
    s_en = 1'b0;
    repeat (3) begin
      step();
      chk("en_off_valid", OUT_valid, 0);
      chk("en_off_ready", IN_ready, 0);
    end
    s_en = 1'b1;
    n = 4;
    do begin
      step();
      n++;
    end while (!OUT_valid && n < 30);
    chk("en_stall_lat", n, 9);
    wait_drain(100);

    // Reset in the middle of an unload.
    mark = hist_idx.size();
    send_frame(3, 1'b1, N, 1'b1);
    n = 0;
    while (hist_idx.size() < mark + 5 && n < 100) begin
      step();
      n++;
    end
    chk("pre_rst_beats", hist_idx.size() - mark, 5);
    s_rst = 1'b1;
    step();
    chk("mid_rst_valid", OUT_valid, 0);
    chk("mid_rst_last", OUT_last, 0);
    step();
    chk("mid_rst_valid2", OUT_valid, 0);
    q.delete();
    s_rst = 1'b0;
    step();
    chk("mid_rst_ready", IN_ready, 1);
    chk("mid_rst_valid3", OUT_valid, 0);
    mark = hist_idx.size();
    send_frame(2, 1'b0, N, 1'b1);
    wait_drain(100);
    chk("rst_new_idx0", hist_idx[mark], 0);
    chk("rst_new_beats", hist_idx.size() - mark, N);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
